axi_bresp_merge: RTL and testbench
==================================

# axi_bresp_merge

Write-response merger between the MMU's write-response channel and the actual master. When the write-address path splits one master burst into several sub-bursts, it pushes one tracking entry per original burst: ID and sub-burst count. This block consumes the per-sub-burst B responses from the write-response channel and emits exactly one merged B response per original burst toward the master. All logic is single-clock, and responses are processed strictly in tracker order.

## Interface
- ID_WIDTH, 8, AXI ID width.
- USER_WIDTH, 2, BUSER width.
- CNT_WIDTH, 2, width of sub-burst count field; max 2^CNT_WIDTH sub-bursts per burst.
- TRK_DEPTH, 8, tracking FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  block clock.
- reset_  in  1  asynchronous, active-low reset.
- in_trk_id  in  ID_WIDTH  ID of split burst.
- in_trk_cnt  in  CNT_WIDTH  number of sub-bursts minus 1.
- in_trk_valid  in  1  tracker push request.
- out_trk_ready  out  1  tracker has space.
- in_sbid  in  ID_WIDTH  sub-burst response ID.
- in_sbresp  in  2  sub-burst BRESP.
- in_sbuser  in  USER_WIDTH  sub-burst BUSER.
- in_sbvalid  in  1  sub-burst response valid.
- out_sbready  out  1  sub-burst response accepted.
- out_bid  out  ID_WIDTH  merged response ID.
- out_bresp  out  2  merged BRESP.
- out_buser  out  USER_WIDTH  merged BUSER.
- out_bvalid  out  1  merged response valid.
- in_bready  in  1  master ready.
- out_id_err  out  1  one-cycle pulse on ID mismatch.
- out_trk_level  out  $clog2(TRK_DEPTH)+1  tracker occupancy.

## Operation
- Tracker: synchronous FIFO of {id, cnt}.
  - Push when in_trk_valid & out_trk_ready.
  - out_trk_ready = (level != TRK_DEPTH).
  - Pop on the merged-response handshake.
- FSM states: IDLE, ACCUM, RESP.
- IDLE:
  - If the tracker is non-empty: load head into id_r and rem_r (= cnt), set worst_r = 00 and xok_r = 1, then go to ACCUM.
  - Otherwise stay in IDLE.
- ACCUM:
  - out_sbready = 1; it is 0 in every other state.
  - On accept (in_sbvalid & out_sbready):
    - worst_r = max(worst_r, in_sbresp), severity order OKAY(00) < SLVERR(10) < DECERR(11); EXOKAY(01) counts as OKAY for severity.
    - xok_r &= (in_sbresp == 01).
    - user_r = in_sbuser.
  - ID check: if in_sbid != id_r, pulse out_id_err for one cycle and force worst_r to at least SLVERR(10).
  - If rem_r == 0 on accept, go to RESP; otherwise rem_r decrements.
- Merged BRESP:
  - EXOKAY(01) only if cnt == 0 and xok_r (the single beat was EXOKAY with matching ID).
  - Otherwise worst_r.
  - out_buser = user of the last sub-response.
  - out_bid = id_r.
- RESP:
  - out_bvalid = 1; outputs held stable until in_bready.
  - On handshake: pop tracker, go to IDLE.
- Sub-responses arriving while in IDLE or RESP are stalled (out_sbready = 0), never dropped.

## Timing
- Reset values (asynchronous, active-low): state = IDLE, tracker empty, out_trk_level = 0, out_trk_ready = 1. All of the following are 0: out_sbready, out_bvalid, out_bid, out_bresp, out_buser, out_id_err.
- Reset mid-operation: tracker contents and partial merge are discarded. No merged response is emitted for them.
- out_sbready and out_bvalid are decoded from registered state only, with no combinational path from inputs.
- Latency:
  - Last sub-response accepted in cycle N → out_bvalid = 1 in cycle N+1.
  - Tracker push in cycle N with FSM in IDLE and tracker empty → ACCUM in N+2 (level visible N+1, load N+1).
- Throughput: one merged burst per (cnt+1) + 2 cycles minimum (IDLE, ACCUM beats, RESP), assuming in_bready = 1.
- Simultaneous push and pop: both take effect; level unchanged. A push when full is ignored by the tracker and must not corrupt state.
- Pointers wrap modulo TRK_DEPTH; level saturates at TRK_DEPTH, never exceeds it.
- Empty tracker with in_sbvalid = 1: FSM stays in IDLE and out_sbready stays 0.

## Test plan
- Single burst: push {id=0x12, cnt=0}, one B with id 0x12 and resp 01 → one out_b with id 0x12 and resp 01, out_bvalid asserted the cycle after accept.
- Split 3 ways: push {0x34, cnt=2}; B resps 00, 10, 00; user 1, 2, 3 → one out_b with id 0x34, resp 10, user 3. out_sbready is low for one cycle after the third accept.
- EXOKAY in split: push {0x05, cnt=1}; resps 01, 01 → merged resp 00.
- ID mismatch: push {0x07, cnt=0}; B with id 0x08 resp 00 → out_id_err pulses once, merged resp 10, id 0x07.
- Backpressure and full: push TRK_DEPTH entries with in_bready = 0 → out_trk_ready = 0 and level = 8. An extra push is ignored. Releasing in_bready drains 8 merged responses in order.
- Reset mid-ACCUM: assert reset_ = 0 after 1 of 3 sub-responses → all outputs 0 immediately, level = 0, no out_bvalid after release.

Source files
------------

// File: rtl/axi_bresp_merge.sv
// Merges per-sub-burst B responses into one B response per original burst.
// Tracker FIFO holds {id, cnt}; responses are processed strictly in order.
module axi_bresp_merge #(
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 2,
  parameter int CNT_WIDTH  = 2,
  parameter int TRK_DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset_,
  input  logic [ID_WIDTH-1:0]          in_trk_id,
  input  logic [CNT_WIDTH-1:0]         in_trk_cnt,
  input  logic                         in_trk_valid,
  output logic                         out_trk_ready,
  input  logic [ID_WIDTH-1:0]          in_sbid,
  input  logic [1:0]                   in_sbresp,
  input  logic [USER_WIDTH-1:0]        in_sbuser,
  input  logic                         in_sbvalid,
  output logic                         out_sbready,
  output logic [ID_WIDTH-1:0]          out_bid,
  output logic [1:0]                   out_bresp,
  output logic [USER_WIDTH-1:0]        out_buser,
  output logic                         out_bvalid,
  input  logic                         in_bready,
  output logic                         out_id_err,
  output logic [$clog2(TRK_DEPTH):0]   out_trk_level
);

  localparam int PW = $clog2(TRK_DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = ID_WIDTH + CNT_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [EW-1:0]         r_mem [TRK_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [LW-1:0]         r_level;

  logic [ID_WIDTH-1:0]   r_id;
  logic [CNT_WIDTH-1:0]  r_rem;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [1:0]            r_worst;
  logic                  r_xok;
  logic [USER_WIDTH-1:0] r_user;
  logic                  r_id_err;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_load;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_idmis;
  logic [ID_WIDTH-1:0]   w_head_id;
  logic [CNT_WIDTH-1:0]  w_head_cnt;
  logic [1:0]            w_sev;
  logic [1:0]            w_worst_nxt;

  assign out_trk_ready = (r_level != LW'(TRK_DEPTH));
  assign out_trk_level = r_level;
  assign w_empty       = (r_level == '0);
  assign w_push        = in_trk_valid & out_trk_ready;
  assign w_pop         = out_bvalid & in_bready;
  assign {w_head_id, w_head_cnt} = r_mem[r_rptr];

  assign out_sbready = (r_state == S_ACCUM);
  assign out_bvalid  = (r_state == S_RESP);
  assign w_load      = (r_state == S_IDLE) & ~w_empty;
  assign w_accept    = in_sbvalid & out_sbready;
  assign w_last      = (r_rem == '0);
  assign w_idmis     = (in_sbid != r_id);

  // Codes 00 < 10 < 11 order numerically once EXOKAY folds to OKAY.
  always_comb begin
    w_sev = (in_sbresp == 2'b01) ? 2'b00 : in_sbresp;
    if (w_idmis && w_sev == 2'b00)
      w_sev = 2'b10;
    w_worst_nxt = (w_sev > r_worst) ? w_sev : r_worst;
  end

  assign out_bid   = r_id;
  assign out_buser = r_user;
  assign out_bresp = (r_cnt == '0 && r_xok) ? 2'b01 : r_worst;
  assign out_id_err = r_id_err;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= {in_trk_id, in_trk_cnt};
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PW'(1);
      if (w_pop)
        r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)
        r_level <= r_level + LW'(1);
      else if (!w_push && w_pop)
        r_level <= r_level - LW'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_ACCUM;
      S_ACCUM: if (w_accept && w_last) w_next = S_RESP;
      S_RESP:  if (in_bready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_id     <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_worst  <= 2'b00;
      r_xok    <= 1'b0;
      r_user   <= '0;
      r_id_err <= 1'b0;
    end else begin
      r_id_err <= w_accept & w_idmis;
      if (w_load) begin
        r_id    <= w_head_id;
        r_rem   <= w_head_cnt;
        r_cnt   <= w_head_cnt;
        r_worst <= 2'b00;
        r_xok   <= 1'b1;
      end else if (w_accept) begin
        r_worst <= w_worst_nxt;
        r_xok   <= r_xok & (in_sbresp == 2'b01) & ~w_idmis;
        r_user  <= in_sbuser;
        if (!w_last)
          r_rem <= r_rem - CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_bresp_merge.sv
// Bench for axi_bresp_merge: directed scenarios plus randomized bursts
// checked against a queue-based model of the merge rules.
module tb_axi_bresp_merge;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       reset_;
  logic [7:0] in_trk_id;
  logic [1:0] in_trk_cnt;
  logic       in_trk_valid;
  logic       out_trk_ready;
  logic [7:0] in_sbid;
  logic [1:0] in_sbresp;
  logic [1:0] in_sbuser;
  logic       in_sbvalid;
  logic       out_sbready;
  logic [7:0] out_bid;
  logic [1:0] out_bresp;
  logic [1:0] out_buser;
  logic       out_bvalid;
  logic       in_bready;
  logic       out_id_err;
  logic [3:0] out_trk_level;

  axi_bresp_merge #(
    .ID_WIDTH(8), .USER_WIDTH(2), .CNT_WIDTH(2), .TRK_DEPTH(D)
  ) dut (
    .clk(clk), .reset_(reset_),
    .in_trk_id(in_trk_id), .in_trk_cnt(in_trk_cnt),
    .in_trk_valid(in_trk_valid), .out_trk_ready(out_trk_ready),
    .in_sbid(in_sbid), .in_sbresp(in_sbresp), .in_sbuser(in_sbuser),
    .in_sbvalid(in_sbvalid), .out_sbready(out_sbready),
    .out_bid(out_bid), .out_bresp(out_bresp), .out_buser(out_buser),
    .out_bvalid(out_bvalid), .in_bready(in_bready),
    .out_id_err(out_id_err), .out_trk_level(out_trk_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] id;
    logic [1:0] cnt;
  } ent_t;

  ent_t       q[$];
  logic [7:0] bid_a [4];
  logic [1:0] brs_a [4];
  logic [1:0] bu_a  [4];
  int vectors = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Severity rank: OKAY/EXOKAY 0, SLVERR 2, DECERR 3; bad ID is >= SLVERR.
  function automatic logic [1:0] model_resp(input logic [7:0] id,
                                            input int cnt);
    int sev = 0;
    int s;
    bit allx = 1;
    for (int i = 0; i <= cnt; i++) begin
      s = (brs_a[i] == 2'b10) ? 2 : (brs_a[i] == 2'b11) ? 3 : 0;
      if (bid_a[i] != id && s < 2) s = 2;
      if (s > sev) sev = s;
      if (brs_a[i] != 2'b01 || bid_a[i] != id) allx = 0;
    end
    if (cnt == 0 && allx) return 2'b01;
    return (sev == 0) ? 2'b00 : (sev == 2) ? 2'b10 : 2'b11;
  endfunction

  task automatic push(input logic [7:0] id, input logic [1:0] cnt);
    ent_t e;
    e.id = id;
    e.cnt = cnt;
    in_trk_valid = 1'b1;
    in_trk_id = id;
    in_trk_cnt = cnt;
    if (q.size() < D) q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_trk_valid = 1'b0;
  endtask

  task automatic rand_beats(input logic [7:0] id, input int cnt);
    for (int i = 0; i <= cnt; i++) begin
      bid_a[i] = ($urandom_range(0, 7) == 0) ? (id ^ 8'h01) : id;
      brs_a[i] = 2'($urandom);
      bu_a[i]  = 2'($urandom);
    end
  endtask

  task automatic send_beats(input int n, input logic [7:0] id,
                            input bit fin);
    bit ok;
    for (int i = 0; i < n; i++) begin
      in_sbvalid = 1'b1;
      in_sbid = bid_a[i];
      in_sbresp = brs_a[i];
      in_sbuser = bu_a[i];
      ok = 0;
      for (int k = 0; k < 50 && !ok; k++) begin
        if (out_sbready) ok = 1;
        @(posedge clk);
        @(negedge clk);
      end
      in_sbvalid = 1'b0;
      chk("sb_accept_timeout", 32'(ok), 1);
      chk("id_err_pulse", 32'(out_id_err), 32'(bid_a[i] != id));
      if (fin && i == n - 1) begin
        chk("sbready_after_last", 32'(out_sbready), 0);
        chk("bvalid_after_last", 32'(out_bvalid), 1);
      end
    end
  endtask

  task automatic recv(input logic [7:0] id, input logic [1:0] resp,
                      input logic [1:0] user, input bit pp,
                      input logic [7:0] pid, input logic [1:0] pcnt);
    ent_t e;
    int k = 0;
    while (!out_bvalid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("bvalid_timeout", 32'(out_bvalid), 1);
    chk("bid", 32'(out_bid), 32'(id));
    chk("bresp", 32'(out_bresp), 32'(resp));
    chk("buser", 32'(out_buser), 32'(user));
    in_bready = 1'b1;
    if (pp) begin
      in_trk_valid = 1'b1;
      in_trk_id = pid;
      in_trk_cnt = pcnt;
    end
    @(posedge clk);
    @(negedge clk);
    in_bready = 1'b0;
    in_trk_valid = 1'b0;
    void'(q.pop_front());
    if (pp) begin
      e.id = pid;
      e.cnt = pcnt;
      q.push_back(e);
    end
    chk("bvalid_drop", 32'(out_bvalid), 0);
    chk("level_after_pop", 32'(out_trk_level), 32'(q.size()));
  endtask

  task automatic process_head(input bit pp, input logic [7:0] pid,
                              input logic [1:0] pcnt);
    ent_t e;
    e = q[0];
    send_beats(int'(e.cnt) + 1, e.id, 1);
    recv(e.id, model_resp(e.id, int'(e.cnt)), bu_a[e.cnt], pp, pid, pcnt);
  endtask

  initial begin
    bit seen;
    reset_ = 1'b0;
    in_trk_id = '0;
    in_trk_cnt = '0;
    in_trk_valid = 1'b0;
    in_sbid = '0;
    in_sbresp = '0;
    in_sbuser = '0;
    in_sbvalid = 1'b0;
    in_bready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bvalid", 32'(out_bvalid), 0);
    chk("rst_sbready", 32'(out_sbready), 0);
    chk("rst_bid", 32'(out_bid), 0);
    chk("rst_bresp", 32'(out_bresp), 0);
    chk("rst_buser", 32'(out_buser), 0);
    chk("rst_id_err", 32'(out_id_err), 0);
    chk("rst_level", 32'(out_trk_level), 0);
    chk("rst_trk_ready", 32'(out_trk_ready), 1);
    reset_ = 1'b1;
    @(negedge clk);

    // single EXOKAY beat, plus push-to-ACCUM latency
    push(8'h12, 2'd0);
    chk("lat_level", 32'(out_trk_level), 1);
    chk("lat_sbready_n1", 32'(out_sbready), 0);
    @(negedge clk);
    chk("lat_sbready_n2", 32'(out_sbready), 1);
    bid_a[0] = 8'h12; brs_a[0] = 2'b01; bu_a[0] = 2'd1;
    process_head(0, 8'h0, 2'd0);

    // 3-way split
    push(8'h34, 2'd2);
    bid_a[0] = 8'h34; brs_a[0] = 2'b00; bu_a[0] = 2'd1;
    bid_a[1] = 8'h34; brs_a[1] = 2'b10; bu_a[1] = 2'd2;
    bid_a[2] = 8'h34; brs_a[2] = 2'b00; bu_a[2] = 2'd3;
    chk("split_model", 32'(model_resp(8'h34, 2)), 32'h2);
    process_head(0, 8'h0, 2'd0);

    // EXOKAY within a split merges to OKAY
    push(8'h05, 2'd1);
    bid_a[0] = 8'h05; brs_a[0] = 2'b01; bu_a[0] = 2'd0;
    bid_a[1] = 8'h05; brs_a[1] = 2'b01; bu_a[1] = 2'd2;
    recv_dummy_guard: begin end
    send_beats(2, 8'h05, 1);
    recv(8'h05, 2'b00, 2'd2, 0, 8'h0, 2'd0);

    // ID mismatch
    push(8'h07, 2'd0);
    bid_a[0] = 8'h08; brs_a[0] = 2'b00; bu_a[0] = 2'd1;
    send_beats(1, 8'h07, 1);
    recv(8'h07, 2'b10, 2'd1, 0, 8'h0, 2'd0);
    chk("id_err_once", 32'(out_id_err), 0);

    // fill the tracker, overflow push, then drain in order
    for (int i = 0; i < D; i++)
      push(8'h80 + 8'(i), 2'($urandom));
    chk("full_level", 32'(out_trk_level), D);
    chk("full_ready", 32'(out_trk_ready), 0);
    push(8'hEE, 2'd0);
    chk("full_level_hold", 32'(out_trk_level), D);
    while (q.size() > 0) begin
      rand_beats(q[0].id, int'(q[0].cnt));
      process_head(0, 8'h0, 2'd0);
    end
    chk("drained_level", 32'(out_trk_level), 0);

    // random bursts, with occasional push coinciding with pop
    for (int it = 0; it < 30; it++) begin
      if (q.size() == 0 || $urandom_range(0, 2) == 0)
        push(8'($urandom), 2'($urandom));
      rand_beats(q[0].id, int'(q[0].cnt));
      process_head(1'($urandom) && q.size() < D, 8'($urandom),
                   2'($urandom));
    end
    while (q.size() > 0) begin
      rand_beats(q[0].id, int'(q[0].cnt));
      process_head(0, 8'h0, 2'd0);
    end

    // reset in the middle of an accumulation
    push(8'h40, 2'd2);
    @(negedge clk);
    bid_a[0] = 8'h40; brs_a[0] = 2'b11; bu_a[0] = 2'd3;
    send_beats(1, 8'h40, 0);
    reset_ = 1'b0;
    #1;
    chk("mid_rst_sbready", 32'(out_sbready), 0);
    chk("mid_rst_bvalid", 32'(out_bvalid), 0);
    chk("mid_rst_bid", 32'(out_bid), 0);
    chk("mid_rst_bresp", 32'(out_bresp), 0);
    chk("mid_rst_buser", 32'(out_buser), 0);
    chk("mid_rst_level", 32'(out_trk_level), 0);
    chk("mid_rst_ready", 32'(out_trk_ready), 1);
    q.delete();
    @(negedge clk);
    reset_ = 1'b1;
    in_bready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_bvalid || out_sbready) seen = 1;
    end
    in_bready = 1'b0;
    chk("post_rst_quiet", 32'(seen), 0);
    chk("post_rst_level", 32'(out_trk_level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
